// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L1 cache data store.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_pkg;

  localparam int CACHE_WAYS       = 4;
  localparam int CACHE_SETS       = 8;
  localparam int CACHE_LINE_BYTES = 32;

  // A single way still needs a 1-bit way select so the port never collapses to zero width.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int LINE_W  = 8 * CACHE_LINE_BYTES;
  localparam int INDEX_W = $clog2(CACHE_SETS);
  localparam int WAY_W   = way_bits(CACHE_WAYS);

  typedef logic [LINE_W-1:0]           line_t;
  typedef logic [CACHE_LINE_BYTES-1:0] byte_en_t;
  typedef logic [INDEX_W-1:0]          index_t;
  typedef logic [WAY_W-1:0]            way_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_e;

endpackage

// File: rtl/cache_data_array_nway_data_bank.sv
// One way of the cache data store: SETS lines, byte-masked write, sweep clear, comb read.
// Latency: write/clear land at the clock edge; read is combinational from the stored line.
// Backpressure: none; the caller guarantees clear and write are never requested together.
// Ports:
//   clk                               clock
//   wr_en / wr_index / wr_byte_en / wr_data   byte-masked line write
//   clr_en / clr_index                zero one whole line (sweep port, wins over write)
//   rd_index / rd_data                combinational read of one line
module data_bank #(
  parameter int  SETS       = 8,
  parameter int  LINE_BYTES = 32,
  localparam int LW         = 8 * LINE_BYTES,
  localparam int IW         = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_index,
  input  logic [LINE_BYTES-1:0] wr_byte_en,
  input  logic [LW-1:0]         wr_data,
  input  logic                  clr_en,
  input  logic [IW-1:0]         clr_index,
  input  logic [IW-1:0]         rd_index,
  output logic [LW-1:0]         rd_data
);

  // Storage is deliberately not reset: the top-level sweep zeroes it after reset.
  logic [LW-1:0] mem [SETS];

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_index] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (wr_byte_en[i]) begin
          mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/cache_data_array_nway.sv
// N-way cache data store with byte-masked writes, registered read and hardware line clear.
// Latency: read data 1 cycle after an accepted rd_en; writes land at the accepting edge.
// Backpressure: busy=1 during the clear sweep; rd_en/wr_en are dropped (not stalled) while busy.
// Ports:
//   clk, rst_n                       clock, async active-low reset (reset starts a clear sweep)
//   clear_req / busy                 start a zero-sweep / sweep in progress
//   rd_en, rd_index, rd_way          read request
//   rd_valid, rd_data                registered read response
//   wr_en, wr_index, wr_way, wr_byte_en, wr_data   byte-masked write request
module cache_data_array_nway
  import cache_pkg::*;
#(
  parameter int  WAYS       = CACHE_WAYS,
  parameter int  SETS       = CACHE_SETS,
  parameter int  LINE_BYTES = CACHE_LINE_BYTES,
  localparam int LW         = 8 * LINE_BYTES,
  localparam int IW         = $clog2(SETS),
  localparam int WW         = way_bits(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  rd_en,
  input  logic [IW-1:0]         rd_index,
  input  logic [WW-1:0]         rd_way,
  output logic                  rd_valid,
  output logic [LW-1:0]         rd_data,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_index,
  input  logic [WW-1:0]         wr_way,
  input  logic [LINE_BYTES-1:0] wr_byte_en,
  input  logic [LW-1:0]         wr_data
);

  clr_state_e    state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;

  logic          rd_acc, wr_acc, fwd_hit;
  logic [LW-1:0] bank_rdata [WAYS];
  logic [LW-1:0] rd_sel, rd_merged;

  // Clear FSM. Reset lands in SWEEP so the array is zeroed before first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLR_SWEEP;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          state_d   = CLR_SWEEP;
          clr_cnt_d = '0;
        end
      end
      CLR_SWEEP: begin
        // clear_req is ignored here: a running sweep is never restarted.
        if (clr_cnt_q == IW'(SETS - 1)) begin
          state_d   = CLR_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = CLR_SWEEP;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign busy   = (state_q == CLR_SWEEP);
  assign rd_acc = rd_en & ~busy;
  assign wr_acc = wr_en & ~busy;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    data_bank #(
      .SETS       (SETS),
      .LINE_BYTES (LINE_BYTES)
    ) u_bank (
      .clk        (clk),
      .wr_en      (wr_acc && (wr_way == WW'(w))),
      .wr_index   (wr_index),
      .wr_byte_en (wr_byte_en),
      .wr_data    (wr_data),
      .clr_en     (busy),
      .clr_index  (clr_cnt_q),
      .rd_index   (rd_index),
      .rd_data    (bank_rdata[w])
    );
  end

  // Way mux; a way number beyond WAYS (non power-of-2 configs) reads as zero.
  always_comb begin
    rd_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_way == WW'(w)) begin
        rd_sel = bank_rdata[w];
      end
    end
  end

  // Same-cycle write to the line being read: strobed bytes come from wr_data,
  // since the bank itself only updates at the edge.
  assign fwd_hit = wr_acc && (wr_way == rd_way) && (wr_index == rd_index);

  always_comb begin
    rd_merged = rd_sel;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (fwd_hit && wr_byte_en[i]) begin
        rd_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Output register: rd_data only moves on an accepted read, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= rd_merged;
      end
    end
  end

endmodule

// File: tb/tb_cache_data_array_nway.sv
module tb_cache_data_array_nway;
  import cache_pkg::*;

  localparam int NW = CACHE_WAYS;
  localparam int NS = CACHE_SETS;
  localparam int NB = CACHE_LINE_BYTES;

  logic     clk;
  logic     rst_n;
  logic     clear_req;
  logic     busy;
  logic     rd_en;
  index_t   rd_index;
  way_t     rd_way;
  logic     rd_valid;
  line_t    rd_data;
  logic     wr_en;
  index_t   wr_index;
  way_t     wr_way;
  byte_en_t wr_byte_en;
  line_t    wr_data;

  int    vectors;
  int    miscompares;
  line_t exp_q [$];
  line_t model [NW][NS];
  line_t exp;

  cache_data_array_nway #(
    .WAYS       (NW),
    .SETS       (NS),
    .LINE_BYTES (NB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_index   (rd_index),
    .rd_way     (rd_way),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_way     (wr_way),
    .wr_byte_en (wr_byte_en),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic line_t rep(input logic [7:0] b);
    return {NB{b}};
  endfunction

  function automatic line_t merge(input line_t old, input byte_en_t be, input line_t d);
    line_t r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    clear_req  = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rd_index   = '0;
    rd_way     = '0;
    wr_index   = '0;
    wr_way     = '0;
    wr_byte_en = '0;
    wr_data    = '0;
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) for (int s = 0; s < NS; s++) model[w][s] = '0;
  endtask

  // One write per cycle, full or partial strobe; model follows the specified byte merge.
  task automatic do_write(input int w, input int s, input byte_en_t be, input line_t d);
    wr_en = 1'b1; wr_way = way_t'(w); wr_index = index_t'(s); wr_byte_en = be; wr_data = d;
    @(posedge clk); #1;
    model[w][s] = merge(model[w][s], be, d);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b need 1", busy); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b need 0", rd_valid); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h need 0", rd_data); end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    vectors++; if (n != NS) begin miscompares++; $display("FAIL reset_sweep_len: got %0d cycles need %0d", n, NS); end
    model_clear();
    for (int w = 0; w < NW; w++) begin
      for (int s = 0; s < NS; s++) begin
        rd_en = 1'b1; rd_way = way_t'(w); rd_index = index_t'(s);
        exp_q.push_back(model[w][s]);
        @(posedge clk); #1;
        vectors++;
        if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
          miscompares++; $display("FAIL reset_read_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
        end else begin
          exp = exp_q.pop_front();
          if (rd_data !== exp) begin miscompares++; $display("FAIL reset_read_data w%0d s%0d: got %h need %h", w, s, rd_data, exp); end
        end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_write_read();
    line_t held;
    do_write(2, 3, '1, rep(8'hA5));
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL wr_no_valid: got %b need 0", rd_valid); end
    rd_en = 1'b1; rd_way = way_t'(2); rd_index = index_t'(3);
    exp_q.push_back(rep(8'hA5));
    @(posedge clk); #1;
    rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL raw_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL raw_data: got %h need %h", rd_data, exp); end
    end
    held = rep(8'hA5);
    @(posedge clk); #1;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid_drop: got %b need 0", rd_valid); end
    vectors++; if (rd_data !== held) begin miscompares++; $display("FAIL idle_data_hold: got %h need %h", rd_data, held); end
  endtask

  task automatic test_forward();
    line_t ff_pat;
    ff_pat = rep(8'hFF);
    // Same way/index: low four bytes forwarded, rest from the stored 0x11 line.
    do_write(1, 5, '1, rep(8'h11));
    rd_en = 1'b1; rd_way = way_t'(1); rd_index = index_t'(5);
    wr_en = 1'b1; wr_way = way_t'(1); wr_index = index_t'(5); wr_byte_en = byte_en_t'(32'h0000_000F); wr_data = ff_pat;
    exp = {{(NB-4){8'h11}}, {4{8'hFF}}};
    exp_q.push_back(exp);
    @(posedge clk); #1;
    model[1][5] = merge(model[1][5], wr_byte_en, wr_data);
    rd_en = 1'b0; wr_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL fwd_same_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL fwd_same_data: got %h need %h", rd_data, exp); end
    end
    // Different way: no merge, plain 0x11 line returned; way0/set5 still gets written.
    do_write(1, 5, '1, rep(8'h11));
    rd_en = 1'b1; rd_way = way_t'(1); rd_index = index_t'(5);
    wr_en = 1'b1; wr_way = way_t'(0); wr_index = index_t'(5); wr_byte_en = byte_en_t'(32'h0000_000F); wr_data = ff_pat;
    exp_q.push_back(rep(8'h11));
    @(posedge clk); #1;
    model[0][5] = merge(model[0][5], wr_byte_en, wr_data);
    wr_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL fwd_diff_way_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL fwd_diff_way_data: got %h need %h", rd_data, exp); end
    end
    // Zero strobe is a no-op; then read back way0/set5 to see the earlier partial write landed.
    do_write(1, 5, '0, rep(8'h77));
    rd_way = way_t'(1); rd_index = index_t'(5);
    exp_q.push_back(model[1][5]);
    @(posedge clk); #1;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL zero_be_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL zero_be_data: got %h need %h", rd_data, exp); end
    end
    rd_way = way_t'(0); rd_index = index_t'(5);
    exp_q.push_back({{(NB-4){8'h00}}, {4{8'hFF}}});
    @(posedge clk); #1;
    rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL other_way_write_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL other_way_write_data: got %h need %h", rd_data, exp); end
    end
  endtask

  task automatic test_clear();
    int n;
    do_write(3, 7, '1, rep(8'h3C));
    do_write(0, 0, '1, rep(8'hC3));
    // clear_req with a same-line read+write: access completes with pre-sweep data.
    clear_req = 1'b1;
    rd_en = 1'b1; rd_way = way_t'(3); rd_index = index_t'(7);
    wr_en = 1'b1; wr_way = way_t'(3); wr_index = index_t'(7); wr_byte_en = byte_en_t'(32'hFFFF_0000); wr_data = rep(8'h5A);
    exp_q.push_back({{(NB-16){8'h5A}}, {16{8'h3C}}});
    @(posedge clk); #1;
    clear_req = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL clr_req_access_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL clr_req_access_data: got %h need %h", rd_data, exp); end
    end
    // Hammer reads/writes (and a stray clear_req) during the sweep: all must be dropped.
    rd_way = way_t'(0); rd_index = index_t'(0);
    wr_way = way_t'(1); wr_index = index_t'(2); wr_byte_en = '1; wr_data = rep(8'hEE);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      clear_req = (n == 3);
      @(posedge clk); #1; n++;
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL busy_rd_valid cycle %0d: got %b need 0", n, rd_valid); end
    end
    idle_inputs();
    vectors++; if (n != NS) begin miscompares++; $display("FAIL clear_sweep_len: got %0d cycles need %0d", n, NS); end
    model_clear();
    for (int w = 0; w < NW; w++) begin
      for (int s = 0; s < NS; s++) begin
        rd_en = 1'b1; rd_way = way_t'(w); rd_index = index_t'(s);
        exp_q.push_back(model[w][s]);
        @(posedge clk); #1;
        vectors++;
        if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
          miscompares++; $display("FAIL post_clear_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
        end else begin
          exp = exp_q.pop_front();
          if (rd_data !== exp) begin miscompares++; $display("FAIL post_clear_data w%0d s%0d: got %h need %h", w, s, rd_data, exp); end
        end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_write(0, 1, '1, rep(8'h96));
    clear_req = 1'b1; rd_en = 1'b1; rd_way = way_t'(0); rd_index = index_t'(1);
    exp_q.push_back(rep(8'h96));
    @(posedge clk); #1;
    clear_req = 1'b0; rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("FAIL pre_reset_read_valid: rd_valid=%b pending=%0d", rd_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rd_data !== exp) begin miscompares++; $display("FAIL pre_reset_read_data: got %h need %h", rd_data, exp); end
    end
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_rd_valid: got %b need 0", rd_valid); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL mid_reset_rd_data: got %h need 0", rd_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_reset_busy: got %b need 1", busy); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    vectors++; if (n != NS) begin miscompares++; $display("FAIL mid_reset_sweep_len: got %0d cycles need %0d", n, NS); end
    model_clear();
  endtask

  task automatic test_back_to_back();
    int ws [8];
    int ss [8];
    line_t d;
    byte_en_t be;
    for (int i = 0; i < 8; i++) begin
      ws[i] = i % NW;
      ss[i] = (i * 3) % NS;
      for (int k = 0; k < NB / 4; k++) d[32*k +: 32] = $urandom();
      be = (i == 5) ? byte_en_t'($urandom()) : '1;
      do_write(ws[i], ss[i], be, d);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_way = way_t'(ws[i]); rd_index = index_t'(ss[i]);
      exp_q.push_back(model[ws[i]][ss[i]]);
      @(posedge clk); #1;
      vectors++;
      if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
        miscompares++; $display("FAIL b2b_valid beat %0d: rd_valid=%b pending=%0d", i, rd_valid, exp_q.size());
      end else begin
        exp = exp_q.pop_front();
        if (rd_data !== exp) begin miscompares++; $display("FAIL b2b_data beat %0d: got %h need %h", i, rd_data, exp); end
      end
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_tail_valid: got %b need 0", rd_valid); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_pending: got %0d need 0", exp_q.size()); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_write_read();
    test_forward();
    test_clear();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
